bsg_burst_sequencer: RTL
========================

BSG_BURST_SEQUENCER -- requirements
Module: bsg_burst_sequencer

Interface
REQ-001 Parameter addr_width_p, default 32: width of burst base address and beat address.
REQ-002 Parameter len_width_p, default 8: width of burst length field and beat index.
REQ-003 Parameter stride_p, default 1: address increment per beat; SHALL be nonzero.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 v_i  in  1  burst request valid.
REQ-007 ready_o  out  1  sequencer accepts a request this cycle.
REQ-008 addr_i  in  addr_width_p  burst base address.
REQ-009 len_i  in  len_width_p  beats minus one (0 = single beat).
REQ-010 v_o  out  1  beat valid.
REQ-011 yumi_i  in  1  consumer takes the current beat; only legal when v_o=1.
REQ-012 addr_o  out  addr_width_p  current beat address.
REQ-013 beat_o  out  len_width_p  current beat index, 0-based.
REQ-014 last_o  out  1  current beat is the final beat of the burst.
REQ-015 busy_o  out  1  a burst is in progress (state BURST).

Function
REQ-016 Two-state FSM: IDLE, BURST.
REQ-017 Handshake: request accepted when v_i & ready_o; beat consumed when v_o & yumi_i.
REQ-018 ready_o = 1 in IDLE; in BURST, ready_o = last_o & yumi_i (zero-bubble chaining).
REQ-019 On accept: base loaded into address register, beat counter set to 0, stored length = len_i, next state BURST.
REQ-020 Latency: request accepted in cycle N -> v_o=1 with beat 0 in cycle N+1.
REQ-021 v_o = 1 exactly while in BURST; addr_o, beat_o, last_o held stable while v_o & ~yumi_i.
REQ-022 On non-last yumi: beat counter +1, address += stride_p, modulo 2^addr_width_p (silent wrap).
REQ-023 last_o = (beat_o == stored length).
REQ-024 On last yumi without new accept: next state IDLE, v_o=0 next cycle.
REQ-025 On last yumi with simultaneous accept: stay BURST, beat 0 of new burst presented next cycle.
REQ-026 len_i = all-ones: exactly 2^len_width_p beats, beat counter never wraps.
REQ-027 v_i while busy and not on last yumi: not accepted, no state change.

Reset
REQ-028 reset_n_i low: immediately state IDLE, v_o=0, busy_o=0, last_o=0, addr_o=0, beat_o=0, ready_o=1.
REQ-029 Reset mid-burst discards the burst; no beat is re-presented after release.
REQ-030 First accept possible on the first rising edge after reset_n_i deasserts.

Configuration
REQ-031 Macro BSG_BURST_SEQUENCER_ABORT_EN: when defined, adds input abort_i (1 bit); abort_i=1 in BURST forces IDLE next cycle, v_o=0 next cycle, any yumi that cycle completes, and no accept in that cycle (ready_o=0).
REQ-032 Without BSG_BURST_SEQUENCER_ABORT_EN: abort_i port absent; bursts only end via last yumi or reset.

Structure
REQ-033 Package bsg_burst_sequencer_pkg SHALL hold the state enum typedef (IDLE, BURST) and the request struct typedef (addr, len).
REQ-034 Beat index SHALL be an instance of bsg_counter_set_en (set on accept with val 0, en on non-last yumi); address register and FSM in this module.

Verification
REQ-035 len_i=3, addr_i=0x100, stride_p=4, yumi_i always 1 -> beats 0..3 at 0x100,0x104,0x108,0x10C, last_o on beat 3, v_o=0 after.
REQ-036 len_i=0 -> single beat, last_o=1 with beat_o=0, return to IDLE.
REQ-037 Back-to-back: second v_i on last yumi -> next cycle beat 0 of second burst, no bubble, busy_o stays 1.
REQ-038 Random yumi_i stalls -> outputs stable while stalled, beat order unchanged.
REQ-039 addr_i=0xFFFFFFFE, stride_p=1, len_i=3 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-040 reset_n_i low at beat 2 of 5 -> v_o=0 immediately; after release ready_o=1, new request starts at beat 0; with ABORT_EN, abort_i at beat 2 -> v_o=0 next cycle.

Source files
------------

// File: rtl/bsg_burst_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | bsg_burst_sequencer_pkg                                              |
// | Shared types for the burst sequencer: FSM state and request layout.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package bsg_burst_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int c_REQ_ADDR_WIDTH = 32;
  localparam int c_REQ_LEN_WIDTH  = 8;

  // Request as seen on the upstream side at the default widths.
  typedef struct packed {
    logic [c_REQ_ADDR_WIDTH-1:0] addr;
    logic [c_REQ_LEN_WIDTH-1:0]  len;
  } req_s;

endpackage

`default_nettype wire

// File: rtl/bsg_counter_set_en.sv
// +----------------------------------------------------------------------+
// | bsg_counter_set_en                                                   |
// | Up-counter with synchronous load (priority) and count enable.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bsg_counter_set_en #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               set_i,
  input  logic               en_i,
  input  logic [width_p-1:0] val_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (set_i) begin
      r_count <= val_i;
    end else if (en_i) begin
      r_count <= r_count + width_p'(1);
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bsg_burst_sequencer.sv
// +----------------------------------------------------------------------+
// | bsg_burst_sequencer                                                  |
// | Expands (base, len) requests into a stream of beat addresses.        |
// | Optional abort input enabled by BSG_BURST_SEQUENCER_ABORT_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bsg_burst_sequencer
  import bsg_burst_sequencer_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int len_width_p  = 8,
  parameter int stride_p     = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [len_width_p-1:0]  len_i,
`ifdef BSG_BURST_SEQUENCER_ABORT_EN
  input  logic                    abort_i,
`endif
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [addr_width_p-1:0] addr_o,
  output logic [len_width_p-1:0]  beat_o,
  output logic                    last_o,
  output logic                    busy_o
);

  localparam logic [addr_width_p-1:0] c_STRIDE = addr_width_p'(stride_p);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [addr_width_p-1:0] r_addr;
  logic [len_width_p-1:0]  r_len;
  logic [len_width_p-1:0]  w_beat;
  logic                    w_last;
  logic                    w_abort;
  logic                    w_accept;
  logic                    w_consume;
  logic                    w_advance;

`ifdef BSG_BURST_SEQUENCER_ABORT_EN
  assign w_abort = abort_i & (r_state == BURST);
`else
  assign w_abort = 1'b0;
`endif

  assign w_last    = (r_state == BURST) & (w_beat == r_len);
  assign w_accept  = v_i & ready_o;
  assign w_consume = v_o & yumi_i;
  // Only non-final beats step the counter, so an all-ones length never wraps.
  assign w_advance = w_consume & ~w_last & ~w_abort;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = BURST;
      end
      BURST: begin
        if (w_abort) begin
          w_state_next = IDLE;
        end else if (w_consume && w_last) begin
          w_state_next = w_accept ? BURST : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Ready in BURST is taken combinationally from yumi so chained bursts have no bubble.
  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    busy_o  = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
      end
      BURST: begin
        v_o     = 1'b1;
        busy_o  = 1'b1;
        ready_o = w_last & yumi_i & ~w_abort;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_addr <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_addr <= addr_i;
      r_len  <= len_i;
    end else if (w_advance) begin
      r_addr <= r_addr + c_STRIDE;
    end
  end

  bsg_counter_set_en #(
    .width_p (len_width_p)
  ) u_beat_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .set_i     (w_accept),
    .en_i      (w_advance),
    .val_i     ({len_width_p{1'b0}}),
    .count_o   (w_beat)
  );

  assign addr_o = r_addr;
  assign beat_o = w_beat;
  assign last_o = w_last;

endmodule

`default_nettype wire
